// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   A 16 x 32 register file with three combinational read ports and one
//   writeback port. Each register has a small pending-write counter. Issue
//   increments the counter with a lock, and writeback decrements it. Any
//   qualified read of a register that still has a pending write after this
//   cycle's writeback raises hazard_stall.
//
// Ports
//   clk                    clock; all state changes on posedge
//   Nrst                   synchronous active-low reset
//   read_0/1/2 [3:0]       read register numbers
//   read_en [2:0]          per-port qualifier for the hazard check
//   rdata_0/1/2 [31:0]     read data, with same-cycle writeback bypass
//   lock_valid, lock_num   destination reservation request
//   lock_ready             reservation can be accepted this cycle
//   write_valid, write_num, write_data   writeback
//   hazard_stall           a qualified read hits an unresolved pending write
module reg_file_scoreboard #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [3:0]  read_0,
  input  logic [3:0]  read_1,
  input  logic [3:0]  read_2,
  input  logic [2:0]  read_en,
  output logic [31:0] rdata_0,
  output logic [31:0] rdata_1,
  output logic [31:0] rdata_2,
  input  logic        lock_valid,
  input  logic [3:0]  lock_num,
  output logic        lock_ready,
  input  logic        write_valid,
  input  logic [3:0]  write_num,
  input  logic [31:0] write_data,
  output logic        hazard_stall
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs [16];
  logic [PEND_W-1:0] pend [16];
  logic [3:0]        rd_num [3];
  logic              lock_fire;

  assign rd_num[0] = read_0;
  assign rd_num[1] = read_1;
  assign rd_num[2] = read_2;

  assign rdata_0 = (write_valid && write_num == read_0) ? write_data : regs[read_0];
  assign rdata_1 = (write_valid && write_num == read_1) ? write_data : regs[read_1];
  assign rdata_2 = (write_valid && write_num == read_2) ? write_data : regs[read_2];

  // A full counter can still accept a lock when a writeback retires one
  // reservation on the same register in the same cycle.
  assign lock_ready = (pend[lock_num] != PEND_MAX) ||
                      (write_valid && write_num == lock_num);
  assign lock_fire  = lock_valid && lock_ready;

  // The effective pending count is nonzero unless the last outstanding write
  // lands this cycle. That read is then served by the bypass.
  always_comb begin
    hazard_stall = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (read_en[p] && pend[rd_num[p]] != '0 &&
          !(pend[rd_num[p]] == PEND_ONE && write_valid && write_num == rd_num[p]))
        hazard_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      if (write_valid)
        regs[write_num] <= write_data;
      for (int i = 0; i < 16; i++) begin
        // A lock and a write to the same register cancel. The increment
        // and the decrement are treated as one reservation handed over.
        if (lock_fire && lock_num == 4'(i)) begin
          if (!(write_valid && write_num == 4'(i)))
            pend[i] <= pend[i] + PEND_ONE;
        end else if (write_valid && write_num == 4'(i) && pend[i] != '0) begin
          pend[i] <= pend[i] - PEND_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;
  logic        clk = 1'b0;
  logic        Nrst;
  logic [3:0]  read_0, read_1, read_2;
  logic [2:0]  read_en;
  logic [31:0] rdata_0, rdata_1, rdata_2;
  logic        lock_valid;
  logic [3:0]  lock_num;
  logic        lock_ready;
  logic        write_valid;
  logic [3:0]  write_num;
  logic [31:0] write_data;
  logic        hazard_stall;

  int total = 0;
  int bad   = 0;

  reg_file_scoreboard #(.PEND_W(2)) dut (
    .clk(clk), .Nrst(Nrst),
    .read_0(read_0), .read_1(read_1), .read_2(read_2), .read_en(read_en),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rdata_2(rdata_2),
    .lock_valid(lock_valid), .lock_num(lock_num), .lock_ready(lock_ready),
    .write_valid(write_valid), .write_num(write_num), .write_data(write_data),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge. Checks run #1 later, well
  // before the next rising edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    lock_valid = 1'b0; write_valid = 1'b0; read_en = 3'b000;
  endtask

  initial begin
    Nrst = 1'b0; read_0 = '0; read_1 = '0; read_2 = '0; read_en = '0;
    lock_valid = 1'b0; lock_num = '0; write_valid = 1'b0; write_num = '0;
    write_data = '0;
    @(negedge clk);
    tick;
    Nrst = 1'b1;

    // 1: reset state, all registers on all ports
    for (int r = 0; r < 16; r++) begin
      read_0 = 4'(r); read_1 = 4'(r); read_2 = 4'(r); read_en = 3'b111;
      lock_num = 4'(r);
      #1;
      check("rst_rdata_0", rdata_0, 32'h0);
      check("rst_rdata_1", rdata_1, 32'h0);
      check("rst_rdata_2", rdata_2, 32'h0);
      check("rst_hazard", hazard_stall, 32'h0);
      check("rst_lock_ready", lock_ready, 32'h1);
    end
    idle;

    // 2: bypass and registered read
    write_valid = 1'b1; write_num = 4'd3; write_data = 32'hDEADBEEF;
    read_1 = 4'd3; read_0 = 4'd0; read_2 = 4'd3;
    #1;
    check("bypass_rdata_1", rdata_1, 32'hDEADBEEF);
    check("bypass_rdata_2", rdata_2, 32'hDEADBEEF);
    check("bypass_other_port", rdata_0, 32'h0);
    tick;
    write_valid = 1'b0; read_0 = 4'd3;
    #1;
    check("stored_rdata_0", rdata_0, 32'hDEADBEEF);

    // 3: lock r5, then a stall that is cleared by a same-cycle writeback
    lock_valid = 1'b1; lock_num = 4'd5; read_en = 3'b001; read_0 = 4'd5;
    #1;
    check("lock5_ready", lock_ready, 32'h1);
    check("lock5_no_same_cycle_hazard", hazard_stall, 32'h0);
    tick;
    lock_valid = 1'b0;
    #1;
    check("r5_hazard", hazard_stall, 32'h1);
    read_en = 3'b000;
    #1;
    check("r5_hazard_unqualified", hazard_stall, 32'h0);
    read_en = 3'b001;
    write_valid = 1'b1; write_num = 4'd5; write_data = 32'd7;
    #1;
    check("r5_hazard_bypassed", hazard_stall, 32'h0);
    check("r5_rdata_0", rdata_0, 32'd7);
    tick;
    write_valid = 1'b0;
    #1;
    check("r5_hazard_after", hazard_stall, 32'h0);
    check("r5_rdata_after", rdata_0, 32'd7);
    idle;

    // 4: saturate r2 at three pending writes
    lock_valid = 1'b1; lock_num = 4'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("r2_lock_ready", lock_ready, 32'h1);
      tick;
    end
    #1;
    check("r2_full_not_ready", lock_ready, 32'h0);
    tick;  // refused lock is held and has no effect
    write_valid = 1'b1; write_num = 4'd2; write_data = 32'h22;
    #1;
    check("r2_full_ready_with_write", lock_ready, 32'h1);
    tick;
    lock_valid = 1'b0; write_valid = 1'b0;
    #1;
    check("r2_still_full", lock_ready, 32'h0);
    read_en = 3'b100; read_2 = 4'd2;
    for (int k = 0; k < 3; k++) begin
      write_valid = 1'b0;
      #1;
      check("r2_drain_hazard", hazard_stall, 32'h1);
      write_valid = 1'b1; write_num = 4'd2; write_data = 32'h200 + 32'(k);
      #1;
      check("r2_drain_hazard_w", hazard_stall, (k == 2) ? 32'h0 : 32'h1);
      tick;
    end
    write_valid = 1'b0;
    #1;
    check("r2_drained", hazard_stall, 32'h0);
    check("r2_rdata", rdata_2, 32'h202);
    idle;

    // 5: lock + write r9 while pend[r9] = 1
    lock_valid = 1'b1; lock_num = 4'd9;
    tick;
    write_valid = 1'b1; write_num = 4'd9; write_data = 32'h99;
    #1;
    check("r9_lock_ready", lock_ready, 32'h1);
    tick;
    lock_valid = 1'b0; write_valid = 1'b0; read_en = 3'b010; read_1 = 4'd9;
    #1;
    check("r9_hazard_persists", hazard_stall, 32'h1);
    check("r9_rdata", rdata_1, 32'h99);
    write_valid = 1'b1; write_num = 4'd9; write_data = 32'h9A;
    tick;
    write_valid = 1'b0;
    #1;
    check("r9_released", hazard_stall, 32'h0);
    idle;

    // 6: reset with outstanding locks, write during reset ignored
    lock_valid = 1'b1; lock_num = 4'd4;
    tick;
    lock_num = 4'd6;
    tick;
    lock_valid = 1'b0;
    Nrst = 1'b0; write_valid = 1'b1; write_num = 4'd7; write_data = 32'h77;
    tick;
    Nrst = 1'b1; write_valid = 1'b0;
    read_0 = 4'd4; read_1 = 4'd6; read_2 = 4'd3; read_en = 3'b011;
    #1;
    check("rst2_hazard_r4_r6", hazard_stall, 32'h0);
    check("rst2_rdata_r3", rdata_2, 32'h0);
    read_2 = 4'd7;
    #1;
    check("rst2_write_ignored", rdata_2, 32'h0);
    read_2 = 4'd9;
    #1;
    check("rst2_rdata_r9", rdata_2, 32'h0);
    write_valid = 1'b1; write_num = 4'd4; write_data = 32'h55;
    tick;
    write_valid = 1'b0; lock_num = 4'd4;
    #1;
    check("r4_no_underflow_hazard", hazard_stall, 32'h0);
    check("r4_no_underflow_ready", lock_ready, 32'h1);
    check("r4_rdata", rdata_0, 32'h55);
    lock_valid = 1'b1;
    tick;
    lock_valid = 1'b0;
    #1;
    check("r4_single_lock_hazard", hazard_stall, 32'h1);
    idle;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
